hesap_denetleyici: RTL
======================

// Module: hesap_denetleyici
// PURPOSE
//  Sequencer between the host and the seven calculator units (add, sub, mul, div, sqrt, tan, cot).
//  Accepts one request over a valid/ready handshake, latches operands and holds them stable, pulses the selected unit's start.
//  Waits for that unit's done pulse or a timeout, then returns one registered, back-pressured result.
//  Strictly one operation in flight.
// PARAMETERS
//  GENISLIK     32  operand width; result width is 2*GENISLIK
//  ZAMAN_ASIMI  64  max BEKLE cycles before timeout (>=2)
//  SAYAC_W      7   timeout counter width, >= clog2(ZAMAN_ASIMI+1)
// PORTS
//  clk            in   1            rising-edge clock
//  rst_n          in   1            async active-low reset
//  istek_gecerli  in   1            host request valid
//  istek_hazir    out  1            controller accepts request
//  sayi1, sayi2   in   GENISLIK     operands
//  tur            in   3            op code 000..110 = unit 0..6; 111 = illegal
//  islem_sayi1/2  out  GENISLIK     latched operands to all units
//  baslat         out  7            one-hot, 1-cycle start pulse to unit[tur]
//  birim_hazir    in   7            per-unit 1-cycle done pulse
//  birim_gecerli  in   7            per-unit result-valid, sampled with done
//  birim_tasma    in   7            per-unit overflow, sampled with done
//  birim_sonuc    in   7*2*GENISLIK flattened unit results, unit i at [i*2G +: 2G]
//  sonuc          out  2*GENISLIK   captured result
//  gecerli, tasma out  1            captured unit flags
//  zaman_asimi    out  1            timeout occurred
//  cikis_gecerli  out  1            result valid to host
//  cikis_hazir    in   1            host takes result
// BEHAVIOUR
//  Reset: state BOSTA; every output 0 except istek_hazir=1; counter 0.
//  FSM: BOSTA -> BASLAT -> BEKLE -> SONUC -> BOSTA.
//  Illegal path: BOSTA -> SONUC directly, with all flags 0.
//  BOSTA: istek_hazir=1. Handshake (istek_gecerli & istek_hazir) at edge N latches sayi1/2 and tur.
//    tur!=111: go to BASLAT. tur==111: go to SONUC with sonuc=0, gecerli=0, tasma=0, zaman_asimi=0.
//  BASLAT (cycle N+1): baslat[tur]=1 for exactly this cycle; counter cleared; next BEKLE.
//  BEKLE: counter increments each cycle.
//    birim_hazir[tur]=1: capture sonuc, gecerli and tasma of unit[tur]; go to SONUC.
//    Unit done in cycle N+1+L gives cikis_gecerli=1 at cycle N+2+L.
//    Counter reaches ZAMAN_ASIMI with no done: sonuc=0, gecerli=0, tasma=0, zaman_asimi=1; go to SONUC.
//    Done and timeout in the same cycle: done wins.
//  SONUC: cikis_gecerli=1; outputs held stable until cikis_hazir=1, then go to BOSTA next edge.
//    No combinational path from cikis_hazir to istek_hazir; minimum issue interval is 4 cycles.
//  islem_sayi1/2 change only on handshake; stable from BASLAT through SONUC.
//  Ignored: done pulses from non-selected units; any done pulse outside BEKLE, including a late pulse after timeout.
//  Output registers (sonuc, flags) keep their value in BOSTA until the next capture.
//  rst_n low in any state: immediate return to reset values; baslat drops asynchronously.
// CONFIGURATION
//  HESAP_ISTATISTIK_EN defined:
//    adds outputs tamamlanan_sayisi[15:0] and hata_sayisi[15:0].
//    tamamlanan_sayisi counts SONUC->BOSTA exits with gecerli=1.
//    hata_sayisi counts exits with gecerli=0 (illegal op, unit invalid, timeout).
//    Both saturate at 16'hFFFF; both reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package hesap_pkg:
//    TUR_TOPLAMA..TUR_KOTANJANT = 3'b000..3'b110, TUR_GECERSIZ = 3'b111;
//    state encodings BOSTA/BASLAT/BEKLE/SONUC; BIRIM_SAYISI = 7.
//  Sub-module zaman_asimi_sayaci (clear, enable, limit-reached) is natural; rest stays in one FSM.
// TESTING
//  1. tur=000, 5+7, unit done 3 cycles after baslat, cikis_hazir=1
//     -> baslat=7'b0000001 at N+1; sonuc=12, gecerli=1 at N+5; istek_hazir back 1 cycle later.
//  2. tur=111 -> no baslat; cikis_gecerli next cycle with gecerli=0, zaman_asimi=0.
//  3. tur=011, unit never done, ZAMAN_ASIMI=64
//     -> zaman_asimi=1, sonuc=0 after 64 BEKLE cycles; a late done pulse afterwards is ignored.
//  4. cikis_hazir=0 for 10 cycles
//     -> outputs stable, istek_hazir=0 throughout, a new istek_gecerli is not accepted.
//  5. rst_n low during BEKLE -> all outputs 0, istek_hazir=1; a following request completes normally.
//  6. done pulse on unit 2 while tur=4 selected -> ignored; only unit 4's pulse is captured.

Source files
------------

// File: rtl/hesap_pkg.sv
// Shared op codes, FSM state encodings and unit-select helper for the calculator sequencer.
// Latency: none (definitions only).
// Backpressure: not applicable.
package hesap_pkg;

    localparam int BIRIM_SAYISI = 7;

    localparam logic [2:0] TUR_TOPLAMA   = 3'b000;
    localparam logic [2:0] TUR_CIKARMA   = 3'b001;
    localparam logic [2:0] TUR_CARPMA    = 3'b010;
    localparam logic [2:0] TUR_BOLME     = 3'b011;
    localparam logic [2:0] TUR_KAREKOK   = 3'b100;
    localparam logic [2:0] TUR_TANJANT   = 3'b101;
    localparam logic [2:0] TUR_KOTANJANT = 3'b110;
    localparam logic [2:0] TUR_GECERSIZ  = 3'b111;

    localparam logic [1:0] BOSTA  = 2'd0;
    localparam logic [1:0] BASLAT = 2'd1;
    localparam logic [1:0] BEKLE  = 2'd2;
    localparam logic [1:0] SONUC  = 2'd3;

    // One-hot unit mask for an op code; the illegal code selects no unit.
    function automatic logic [BIRIM_SAYISI-1:0] tek_sicak(input logic [2:0] t);
        logic [BIRIM_SAYISI-1:0] maske;
        maske = '0;
        if (t != TUR_GECERSIZ) begin
            maske = BIRIM_SAYISI'(1) << t;
        end
        return maske;
    endfunction

endpackage

// File: rtl/hesap_zaman_asimi_sayaci.sv
// Timeout counter: cleared before a wait, counts wait cycles, flags the last allowed cycle.
// Latency: limit_doldu is combinational on the current count; count updates each enabled edge.
// Backpressure: none; driven purely by the sequencer state.
module hesap_zaman_asimi_sayaci #(
    parameter int LIMIT = 64,
    parameter int W     = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic temizle,
    input  logic etkin,
    output logic limit_doldu
);

    localparam logic [W-1:0] SON_DEGER = W'(LIMIT - 1);

    logic [W-1:0] sayac;

    // Count wait cycles; a clear restarts the window for the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sayac <= '0;
        end else if (temizle) begin
            sayac <= '0;
        end else if (etkin) begin
            sayac <= sayac + W'(1);
        end
    end

    // High during the LIMIT-th wait cycle, so the counter reaches LIMIT on the timeout edge.
    assign limit_doldu = etkin && (sayac == SON_DEGER);

endmodule

// File: rtl/hesap_denetleyici.sv
// Sequencer for seven calculator units: accepts one request, starts the unit, returns one result.
// Latency: start one cycle after accept; result one cycle after unit done; illegal op one cycle.
// Backpressure: result held until cikis_hazir; no new request accepted until the result is taken.
// Optional statistics counters are built when HESAP_ISTATISTIK_EN is defined.
module hesap_denetleyici
    import hesap_pkg::*;
#(
    parameter int GENISLIK    = 32,
    parameter int ZAMAN_ASIMI = 64,
    parameter int SAYAC_W     = 7
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              istek_gecerli,
    output logic                              istek_hazir,
    input  logic [GENISLIK-1:0]               sayi1,
    input  logic [GENISLIK-1:0]               sayi2,
    input  logic [2:0]                        tur,
    output logic [GENISLIK-1:0]               islem_sayi1,
    output logic [GENISLIK-1:0]               islem_sayi2,
    output logic [BIRIM_SAYISI-1:0]           baslat,
    input  logic [BIRIM_SAYISI-1:0]           birim_hazir,
    input  logic [BIRIM_SAYISI-1:0]           birim_gecerli,
    input  logic [BIRIM_SAYISI-1:0]           birim_tasma,
    input  logic [BIRIM_SAYISI*2*GENISLIK-1:0] birim_sonuc,
    output logic [2*GENISLIK-1:0]             sonuc,
    output logic                              gecerli,
    output logic                              tasma,
    output logic                              zaman_asimi,
`ifdef HESAP_ISTATISTIK_EN
    output logic [15:0]                       tamamlanan_sayisi,
    output logic [15:0]                       hata_sayisi,
`endif
    output logic                              cikis_gecerli,
    input  logic                              cikis_hazir
);

    localparam int SW = 2 * GENISLIK;

    logic [1:0]              durum;
    logic [2:0]              tur_q;
    logic [BIRIM_SAYISI-1:0] secim;
    logic                    sec_hazir;
    logic                    sec_gecerli;
    logic                    sec_tasma;
    logic [SW-1:0]           sec_sonuc;
    logic                    limit_doldu;

    assign secim       = tek_sicak(tur_q);
    assign sec_hazir   = |(birim_hazir & secim);
    assign sec_gecerli = |(birim_gecerli & secim);
    assign sec_tasma   = |(birim_tasma & secim);

    // Pick the selected unit's result slice out of the flattened bus.
    always_comb begin
        sec_sonuc = '0;
        for (int i = 0; i < BIRIM_SAYISI; i++) begin
            if (tur_q == 3'(i)) begin
                sec_sonuc = birim_sonuc[i*SW +: SW];
            end
        end
    end

    // Start is decoded from state so it vanishes the instant reset is asserted.
    assign baslat        = (durum == BASLAT) ? secim : '0;
    assign istek_hazir   = (durum == BOSTA);
    assign cikis_gecerli = (durum == SONUC);

    hesap_zaman_asimi_sayaci #(
        .LIMIT (ZAMAN_ASIMI),
        .W     (SAYAC_W)
    ) u_sayac (
        .clk         (clk),
        .rst_n       (rst_n),
        .temizle     (durum == BASLAT),
        .etkin       (durum == BEKLE),
        .limit_doldu (limit_doldu)
    );

    // Main sequencer: latch request, launch unit, wait for done or timeout, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum       <= BOSTA;
            tur_q       <= TUR_TOPLAMA;
            islem_sayi1 <= '0;
            islem_sayi2 <= '0;
            sonuc       <= '0;
            gecerli     <= 1'b0;
            tasma       <= 1'b0;
            zaman_asimi <= 1'b0;
        end else begin
            case (durum)
                BOSTA: begin
                    if (istek_gecerli) begin
                        islem_sayi1 <= sayi1;
                        islem_sayi2 <= sayi2;
                        tur_q       <= tur;
                        if (tur == TUR_GECERSIZ) begin
                            sonuc       <= '0;
                            gecerli     <= 1'b0;
                            tasma       <= 1'b0;
                            zaman_asimi <= 1'b0;
                            durum       <= SONUC;
                        end else begin
                            durum <= BASLAT;
                        end
                    end
                end
                BASLAT: begin
                    durum <= BEKLE;
                end
                BEKLE: begin
                    // A done arriving on the last allowed cycle beats the timeout.
                    if (sec_hazir) begin
                        sonuc       <= sec_sonuc;
                        gecerli     <= sec_gecerli;
                        tasma       <= sec_tasma;
                        zaman_asimi <= 1'b0;
                        durum       <= SONUC;
                    end else if (limit_doldu) begin
                        sonuc       <= '0;
                        gecerli     <= 1'b0;
                        tasma       <= 1'b0;
                        zaman_asimi <= 1'b1;
                        durum       <= SONUC;
                    end
                end
                SONUC: begin
                    if (cikis_hazir) begin
                        durum <= BOSTA;
                    end
                end
                default: begin
                    durum <= BOSTA;
                end
            endcase
        end
    end

`ifdef HESAP_ISTATISTIK_EN
    // Tally results as the host takes them, split by whether the unit reported a valid result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tamamlanan_sayisi <= '0;
            hata_sayisi       <= '0;
        end else if ((durum == SONUC) && cikis_hazir) begin
            if (gecerli) begin
                if (tamamlanan_sayisi != 16'hFFFF) begin
                    tamamlanan_sayisi <= tamamlanan_sayisi + 16'd1;
                end
            end else begin
                if (hata_sayisi != 16'hFFFF) begin
                    hata_sayisi <= hata_sayisi + 16'd1;
                end
            end
        end
    end
`endif

endmodule
